// File: rtl/packet_sink_mc_pkg.sv
// Shared definitions for the multi-channel packet sink.
// Holds the flit bit positions (derived from the flit width), the per-channel
// framing FSM encoding, the stall LFSR seed and the LFSR step function.
`ifndef PACKET_SINK_MC_PKG_SV
`define PACKET_SINK_MC_PKG_SV

package packet_sink_mc_pkg;

  // Per-channel framing state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } ch_state_e;

  localparam int unsigned PKT_CH_W  = 3;
  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // HEAD flag sits in the top bit of the flit
  function automatic int unsigned head_bit(input int unsigned size);
    return size - 1;
  endfunction

  // TAIL flag sits just below HEAD
  function automatic int unsigned tail_bit(input int unsigned size);
    return size - 2;
  endfunction

  // Fibonacci LFSR step for x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

`endif

// File: rtl/packet_sink_mc_rr_arbiter.sv
// Round-robin arbiter with a registered pointer.
// Grants the first requester at or after the pointer; after a grant to g the
// pointer moves to g+1 (mod N). No grant leaves the pointer unchanged.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   en         : arbitration enable; when low no grant is issued, pointer holds
//   req [N]    : request vector
//   grant [N]  : combinational one-hot (or zero) grant, zero while reset is high
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] ptr_next;
  logic             found;

  // Rotating priority search starting at ptr
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    if (en && !reset) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = PTR_W'((32'(ptr) + k) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          gidx       = idx;
          found      = 1'b1;
        end
      end
    end
  end

  assign ptr_next = (gidx == PTR_W'(N - 1)) ? '0 : gidx + PTR_W'(1);

  // Pointer advances only past an actual winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/packet_sink_mc.sv
// Multi-channel packet sink: terminal NoC endpoint that drains N_CH channels,
// accepts at most one flit per cycle (round-robin), checks per-channel framing
// and destination, and keeps saturating packet / flit / error statistics.
// Optional macro PACKET_SINK_RANDOM_STALL_EN adds LFSR-driven back-pressure.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ch_req      : per-channel flit valid
//   ch_flit     : flits, channel i at [i*SIZE +: SIZE]
//   ch_ack      : combinational per-channel accept (one-hot or zero)
//   pkt_count   : good packets received (saturating)
//   flit_count  : flits accepted (saturating)
//   err_count   : framing plus mis-route errors (saturating)
//   pkt_done    : one-cycle pulse after a good packet completes
//   pkt_ch      : channel of the last good packet
module packet_sink_mc
  import packet_sink_mc_pkg::*;
#(
  parameter int unsigned ID        = 0,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned DEST_BITS = 4,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        ch_req,
  input  logic [N_CH*SIZE-1:0]   ch_flit,
  output logic [N_CH-1:0]        ch_ack,
  output logic [CNT_BITS-1:0]    pkt_count,
  output logic [CNT_BITS-1:0]    flit_count,
  output logic [CNT_BITS-1:0]    err_count,
  output logic                   pkt_done,
  output logic [PKT_CH_W-1:0]    pkt_ch
);

  localparam int unsigned HEAD_POS = head_bit(SIZE);
  localparam int unsigned TAIL_POS = tail_bit(SIZE);
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Add with clamp at all-ones
  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [1:0]          b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + (CNT_BITS + 1)'(b);
    return s[CNT_BITS] ? {CNT_BITS{1'b1}} : s[CNT_BITS-1:0];
  endfunction

  logic en;

`ifdef PACKET_SINK_RANDOM_STALL_EN
  logic [LFSR_W-1:0] lfsr;

  // Free-running back-pressure source; stalls when the low two bits are zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED + LFSR_W'(ID);
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign en = (lfsr[1:0] != 2'b00);
`else
  assign en = 1'b1;
`endif

  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .req   (ch_req),
    .grant (ch_ack)
  );

  ch_state_e         state [N_CH];
  logic [N_CH-1:0]   dest_ok;

  logic              xfer;
  logic [CH_W-1:0]   g;
  logic [SIZE-1:0]   flit;
  logic              head;
  logic              tail;
  logic              dest_hit;
  ch_state_e         st_cur;
  ch_state_e         st_nxt;
  logic              dok_nxt;
  logic [1:0]        err_inc;
  logic              good;
  logic              unused_flit_bits;

  // Select the granted channel's flit (ack is one-hot, so at most one match)
  always_comb begin
    xfer = |ch_ack;
    g    = '0;
    flit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_ack[i]) begin
        g    = CH_W'(i);
        flit = ch_flit[i*SIZE +: SIZE];
      end
    end
  end

  // Middle payload bits carry no framing information
  assign unused_flit_bits = ^flit;

  // Framing decision for the granted channel
  always_comb begin
    head     = flit[HEAD_POS];
    tail     = flit[TAIL_POS];
    dest_hit = (flit[DEST_BITS-1:0] == DEST_BITS'(ID));
    st_cur   = state[g];
    st_nxt   = st_cur;
    dok_nxt  = dest_ok[g];
    err_inc  = 2'd0;
    good     = 1'b0;
    if (head) begin
      // A head inside a packet truncates it, then starts afresh
      if (st_cur == ST_BODY) begin
        err_inc = 2'd1;
      end
      if (tail) begin
        st_nxt = ST_IDLE;
        if (dest_hit) begin
          good = 1'b1;
        end else begin
          err_inc = err_inc + 2'd1;
        end
      end else begin
        st_nxt  = ST_BODY;
        dok_nxt = dest_hit;
      end
    end else if (st_cur == ST_IDLE) begin
      err_inc = 2'd1;
    end else if (tail) begin
      st_nxt = ST_IDLE;
      if (dest_ok[g]) begin
        good = 1'b1;
      end else begin
        err_inc = 2'd1;
      end
    end
  end

  // Per-channel FSMs, statistics and completion reporting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i] <= ST_IDLE;
      end
      dest_ok    <= '0;
      pkt_count  <= '0;
      flit_count <= '0;
      err_count  <= '0;
      pkt_done   <= 1'b0;
      pkt_ch     <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (xfer) begin
        state[g]   <= st_nxt;
        dest_ok[g] <= dok_nxt;
        flit_count <= sat_add(flit_count, 2'd1);
        err_count  <= sat_add(err_count, err_inc);
        if (good) begin
          pkt_count <= sat_add(pkt_count, 2'd1);
          pkt_done  <= 1'b1;
          pkt_ch    <= PKT_CH_W'(g);
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_sink_mc.sv
// Self-checking bench for packet_sink_mc.
// Main instance: ID=0, N_CH=2, CNT_BITS=16, checked every cycle against a
// packet-level reference model. Second instance: ID=5, N_CH=3, CNT_BITS=4,
// used for three-way rotation and counter saturation.
module tb_packet_sink_mc;

  logic        clk = 1'b0;
  logic        reset;

  logic [1:0]  ch_req;
  logic [15:0] ch_flit;
  logic [1:0]  ch_ack;
  logic [15:0] pkt_count;
  logic [15:0] flit_count;
  logic [15:0] err_count;
  logic        pkt_done;
  logic [2:0]  pkt_ch;

  logic [2:0]  s_req;
  logic [23:0] s_flit;
  logic [2:0]  s_ack;
  logic [3:0]  s_pkt;
  logic [3:0]  s_flt;
  logic [3:0]  s_err;
  logic        s_done;
  logic [2:0]  s_ch;

  always #5 clk = ~clk;

  packet_sink_mc #(.ID(0), .N_CH(2), .SIZE(8), .DEST_BITS(4), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack),
    .pkt_count(pkt_count), .flit_count(flit_count), .err_count(err_count),
    .pkt_done(pkt_done), .pkt_ch(pkt_ch));

  packet_sink_mc #(.ID(5), .N_CH(3), .SIZE(8), .DEST_BITS(4), .CNT_BITS(4)) dut_s (
    .clk(clk), .reset(reset), .ch_req(s_req), .ch_flit(s_flit), .ch_ack(s_ack),
    .pkt_count(s_pkt), .flit_count(s_flt), .err_count(s_err),
    .pkt_done(s_done), .pkt_ch(s_ch));

  int total = 0;
  int bad   = 0;

  // Reference model state (packet level)
  int          m_ptr;
  bit          m_body [2];
  bit          m_dok  [2];
  int          m_pkt, m_flit, m_err, m_ch;
  bit          m_done;
  logic [15:0] m_lfsr;
  int          done_seen;
  int          non_stall;
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [1:0]  ack_hist [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk(input bit h, input bit t, input logic [3:0] d);
    logic [1:0] pad;
    pad = 2'($urandom);
    return {h, t, pad, d};
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit m_stall();
`ifdef PACKET_SINK_RANDOM_STALL_EN
    return m_lfsr[1:0] == 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_body[0] = 0; m_body[1] = 0;
    m_dok[0] = 0;  m_dok[1] = 0;
    m_pkt = 0; m_flit = 0; m_err = 0; m_ch = 0; m_done = 0;
    m_lfsr = 16'hACE1;
  endtask

  // Apply one accepted flit to the packet-level model
  task automatic model_xfer(input int c, input logic [7:0] f);
    bit h, t, hit;
    int e;
    h = f[7]; t = f[6]; hit = (f[3:0] == 4'd0);
    e = 0;
    m_flit = sat16(m_flit + 1);
    if (m_body[c] && h) begin
      e++;
      m_body[c] = 0;
    end
    if (!m_body[c]) begin
      if (!h) e++;
      else if (t) begin
        if (hit) begin m_pkt = sat16(m_pkt + 1); m_done = 1; m_ch = c; end
        else e++;
      end else begin
        m_body[c] = 1;
        m_dok[c]  = hit;
      end
    end else if (t) begin
      m_body[c] = 0;
      if (m_dok[c]) begin m_pkt = sat16(m_pkt + 1); m_done = 1; m_ch = c; end
      else e++;
    end
    m_err = sat16(m_err + e);
  endtask

  // One clock of the main instance, entered and left at a falling edge
  task automatic step();
    logic [1:0] req;
    logic [1:0] exp_ack;
    logic [7:0] f;
    int         g;
    req[0] = (q0.size() != 0);
    req[1] = (q1.size() != 0);
    ch_req = req;
    ch_flit[7:0]  = req[0] ? q0[0] : 8'($urandom);
    ch_flit[15:8] = req[1] ? q1[0] : 8'($urandom);
    #1;
    exp_ack = 2'b00;
    g = -1;
    if (!m_stall()) begin
      if (req != 2'b00) non_stall++;
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (m_ptr + k) % 2;
        if (g < 0 && req[c]) g = c;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ch_ack", 32'(ch_ack), 32'(exp_ack));
    ack_hist.push_back(ch_ack);
    m_done = 0;
    if (g >= 0) begin
      if (g == 0) begin f = q0.pop_front(); end
      else        begin f = q1.pop_front(); end
      model_xfer(g, f);
      m_ptr = (g + 1) % 2;
    end
    @(posedge clk);
    #1;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    check("pkt_count",  32'(pkt_count),  32'(m_pkt));
    check("flit_count", 32'(flit_count), 32'(m_flit));
    check("err_count",  32'(err_count),  32'(m_err));
    check("pkt_done",   32'(pkt_done),   32'(m_done));
    if (pkt_done) done_seen++;
    if (m_done) check("pkt_ch", 32'(pkt_ch), 32'(m_ch));
    @(negedge clk);
  endtask

  task automatic run_queues(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    step();
    step();
  endtask

  // Reset both instances with requests pending; acks must stay low
  task automatic do_reset();
    reset  = 1'b1;
    ch_req = 2'b11;
    s_req  = 3'b111;
    #1;
    check("ack_in_reset",   32'(ch_ack), 32'd0);
    check("s_ack_in_reset", 32'(s_ack),  32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_pkt",  32'(pkt_count),  32'd0);
    check("rst_flit", 32'(flit_count), 32'd0);
    check("rst_err",  32'(err_count),  32'd0);
    check("rst_done", 32'(pkt_done),   32'd0);
    check("rst_ch",   32'(pkt_ch),     32'd0);
    ch_req = 2'b00;
    s_req  = 3'b000;
    reset  = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int nflits;
    reset = 1'b1;
    ch_req = '0; ch_flit = '0; s_req = '0; s_flit = '0;
    done_seen = 0; non_stall = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Reset in the middle of a packet; the leftovers become orphans
    q0.push_back(mk(1, 0, 4'd0));
    q0.push_back(mk(0, 0, 4'd0));
    run_queues(20);
    do_reset();
    q0.push_back(mk(0, 0, 4'd0));
    q0.push_back(mk(0, 0, 4'd0));
    q0.push_back(mk(0, 1, 4'd0));
    run_queues(20);
    check("midrst_err", 32'(err_count), 32'd3);
    check("midrst_pkt", 32'(pkt_count), 32'd0);

    // Four-flit good packet on ch0
    do_reset();
    done_seen = 0;
    q0.push_back(mk(1, 0, 4'd0));
    q0.push_back(mk(0, 0, 4'd7));
    q0.push_back(mk(0, 0, 4'd3));
    q0.push_back(mk(0, 1, 4'd9));
    run_queues(40);
    check("p4_flit", 32'(flit_count), 32'd4);
    check("p4_pkt",  32'(pkt_count),  32'd1);
    check("p4_err",  32'(err_count),  32'd0);
    check("p4_done", 32'(done_seen),  32'd1);
    check("p4_ch",   32'(pkt_ch),     32'd0);

    // Both channels busy: grants alternate starting at ch0
    do_reset();
    ack_hist.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1, 1, 4'd0));
      q1.push_back(mk(1, 1, 4'd0));
    end
    run_queues(60);
    check("alt_flit", 32'(flit_count), 32'd8);
    check("alt_pkt",  32'(pkt_count),  32'd8);
`ifndef PACKET_SINK_RANDOM_STALL_EN
    for (int k = 0; k < 8; k++) begin
      check("alt_ack", 32'(ack_hist[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
`endif

    // Mis-routed single flit, then a head truncated by another head on ch1
    do_reset();
    q1.push_back(mk(1, 1, 4'd1));
    q1.push_back(mk(1, 0, 4'd0));
    q1.push_back(mk(1, 0, 4'd0));
    run_queues(40);
    check("trunc_err", 32'(err_count), 32'd2);
    check("trunc_pkt", 32'(pkt_count), 32'd0);

    // Truncating head that is itself a bad single-flit packet: +2 at once
    do_reset();
    q0.push_back(mk(1, 0, 4'd0));
    q0.push_back(mk(1, 1, 4'd2));
    run_queues(40);
    check("dbl_err",  32'(err_count),  32'd2);
    check("dbl_flit", 32'(flit_count), 32'd2);

    // Randomised traffic with orphans, truncations and mis-routes
    do_reset();
    nflits = 0;
    for (int p = 0; p < 120; p++) begin
      int kind, len;
      logic [3:0] d;
      bit c;
      c    = 1'($urandom);
      kind = $urandom_range(0, 7);
      len  = $urandom_range(1, 4);
      d    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      if (kind == 0) begin
        if (c) q1.push_back(mk(0, 1'($urandom), 4'($urandom)));
        else   q0.push_back(mk(0, 1'($urandom), 4'($urandom)));
        nflits++;
      end else begin
        for (int i = 0; i < len; i++) begin
          logic [7:0] f;
          f = mk(i == 0, (i == len - 1) && (kind != 1), (i == 0) ? d : 4'($urandom));
          if (c) q1.push_back(f);
          else   q0.push_back(f);
          nflits++;
        end
      end
    end
    run_queues(3000);
    check("rand_flits", 32'(flit_count), 32'(nflits));

    // 100 cycles of continuous request on ch0; every non-stall cycle moves a flit
    do_reset();
    non_stall = 0;
    for (int i = 0; i < 110; i++) q0.push_back(mk(1, 1, 4'd0));
    for (int i = 0; i < 100; i++) step();
    check("stream_flits", 32'(flit_count), 32'(non_stall));
    check("stream_pkts",  32'(pkt_count),  32'(non_stall));
    q0.delete();
    step();

    // Three-channel instance: rotation and saturation
    do_reset();
`ifndef PACKET_SINK_RANDOM_STALL_EN
    s_flit = {mk(1, 1, 4'd5), mk(1, 1, 4'd5), mk(1, 1, 4'd5)};
    s_req  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rot3_ack", 32'(s_ack), 32'(1 << (k % 3)));
      @(negedge clk);
    end
    s_req = 3'b000;
    do_reset();
`endif
    s_flit[15:8] = mk(1, 1, 4'd5);
    s_req = 3'b010;
    acks = 0;
    for (int n = 0; n < 300 && acks < 20; n++) begin
      #1;
      if (s_ack[1]) acks++;
      @(negedge clk);
    end
    s_req = 3'b000;
    check("sat_acks", 32'(acks),  32'd20);
    check("sat_pkt",  32'(s_pkt), 32'd15);
    check("sat_flit", 32'(s_flt), 32'd15);
    check("sat_err",  32'(s_err), 32'd0);
    check("sat_ch",   32'(s_ch),  32'd1);

    s_flit[15:8] = mk(0, 0, 4'd5);
    s_req = 3'b010;
    acks = 0;
    for (int n = 0; n < 300 && acks < 20; n++) begin
      #1;
      if (s_ack[1]) acks++;
      @(negedge clk);
    end
    s_req = 3'b000;
    check("orph_acks", 32'(acks),   32'd20);
    check("orph_err",  32'(s_err),  32'd15);
    check("orph_pkt",  32'(s_pkt),  32'd15);
    check("orph_done", 32'(s_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
